// File: rtl/clyde_inv_sbox_stage.sv
// rtl/clyde_inv_sbox_stage.sv - Clyde-128 inverse S-box layer plus tweakey XOR, two-stage valid/ready pipeline
// Optional one-entry input skid buffer enabled by defining CLYDE_INVS_SKID_EN.
module clyde_inv_sbox_stage #(
    parameter int DW    = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_state,
    input  logic [DW-1:0]    in_tk,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_state,
    output logic             out_last,
    output logic [CNT_W-1:0] beat_cnt
);

    generate
        if (DW != 128) begin : g_dw_check
            $error("clyde_inv_sbox_stage: DW must be 128");
        end
    endgenerate

    // Rows y0..y3 sit MSB-first; the evaluation order below is what makes this the exact inverse.
    function automatic logic [127:0] inv_sbox(input logic [127:0] y);
        logic [31:0] x0, x1, x2, x3;
        x3 = y[63:32]  ^ (y[127:96] & y[95:64]);
        x0 = y[31:0]   ^ (y[95:64]  & x3);
        x1 = y[127:96] ^ (x3 & x0);
        x2 = y[95:64]  ^ (x0 & x1);
        return {x0, x1, x2, x3};
    endfunction

    logic          s1_valid;
    logic          s2_valid;
    logic [DW-1:0] s1_state;
    logic [DW-1:0] s1_tk;
    logic          s1_last;
    logic          s2_load;
    logic          s1_load;
    logic [DW-1:0] src_state;
    logic [DW-1:0] src_tk;
    logic          src_last;

    assign s2_load = s1_valid & (~s2_valid | out_ready);

`ifdef CLYDE_INVS_SKID_EN
    logic          skid_full;
    logic [DW-1:0] skid_state;
    logic [DW-1:0] skid_tk;
    logic          skid_last;
    logic          s1_room;
    logic          in_take;

    assign s1_room  = ~s1_valid | s2_load;
    assign in_ready = ~skid_full;
    assign in_take  = in_valid & ~skid_full;
    // A parked beat always wins S1 so ordering is preserved; input is blocked meanwhile.
    assign s1_load   = skid_full ? s1_room : (in_take & s1_room);
    assign src_state = skid_full ? skid_state : in_state;
    assign src_tk    = skid_full ? skid_tk : in_tk;
    assign src_last  = skid_full ? skid_last : in_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_full <= 1'b0;
        end else if (skid_full & s1_room) begin
            skid_full <= 1'b0;
        end else if (in_take & ~s1_room) begin
            skid_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_take & ~s1_room) begin
            skid_state <= in_state;
            skid_tk    <= in_tk;
            skid_last  <= in_last;
        end
    end
`else
    assign in_ready  = ~s1_valid | s2_load;
    assign s1_load   = in_valid & in_ready;
    assign src_state = in_state;
    assign src_tk    = in_tk;
    assign src_last  = in_last;
`endif

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_state <= inv_sbox(src_state);
            s1_tk    <= src_tk;
            s1_last  <= src_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_state <= '0;
            out_last  <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                s2_valid  <= 1'b1;
                out_state <= s1_state ^ s1_tk;
                out_last  <= s1_last;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
            if (s2_valid & out_ready) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_clyde_inv_sbox_stage.sv
// tb/tb_clyde_inv_sbox_stage.sv - self-checking bench for clyde_inv_sbox_stage
module tb_clyde_inv_sbox_stage;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_tk;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         out_last;
    logic [15:0]  beat_cnt;

    clyde_inv_sbox_stage #(.DW(128), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .in_tk(in_tk), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_last(out_last), .beat_cnt(beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        logic [127:0] tk;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [127:0] st;
        logic         last;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  inv_tab [16];
    exp_t        q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic        have_hold = 1'b0;
    logic [127:0] hold_state;
    logic        hold_last;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: per bit column, look up the inverse of the forward 4-bit S-box.
    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] tk);
        logic [127:0] r;
        logic [3:0]   n;
        logic [3:0]   x;
        for (int i = 0; i < 32; i++) begin
            n = {st[96+i], st[64+i], st[32+i], st[i]};
            x = inv_tab[n];
            r[96+i] = x[3];
            r[64+i] = x[2];
            r[32+i] = x[1];
            r[i]    = x[0];
        end
        return r ^ tk;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            exp_cnt   = 16'd0;
            have_hold = 1'b0;
        end else begin
            if (out_valid && have_hold) begin
                chk("hold_state", out_state, hold_state);
                chk("hold_last", 128'(out_last), 128'(hold_last));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_beat", 128'(1), 128'(0));
                end else begin
                    e = q.pop_front();
                    chk("out_state", out_state, e.st);
                    chk("out_last", 128'(out_last), 128'(e.last));
                    chk("beat_cnt_run", 128'(beat_cnt), 128'(exp_cnt));
                end
                exp_cnt   = exp_cnt + 16'd1;
                have_hold = 1'b0;
            end else if (out_valid) begin
                have_hold  = 1'b1;
                hold_state = out_state;
                hold_last  = out_last;
            end else begin
                have_hold = 1'b0;
            end
            if (in_valid && in_ready) begin
                e.st   = model(in_state, in_tk);
                e.last = in_last;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] st, input logic [127:0] tk,
                         input logic l, input logic ordy, output logic acc);
        in_valid  = v;
        in_state  = st;
        in_tk     = tk;
        in_last   = l;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
        tick();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        chk(nm, 128'(n >= 100), 128'(0));
    endtask

    task automatic one_beat(input logic [127:0] st, input logic [127:0] tk, input logic l,
                            output logic [127:0] got, output logic gl, output int lat);
        in_valid  = 1'b1;
        in_state  = st;
        in_tk     = tk;
        in_last   = l;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        got = out_state;
        gl  = out_last;
        tick();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         tbl [5];
        logic [3:0]   xv;
        logic         a0, a1, a2, a3, b0, b1, b2, b3;
        logic [127:0] got, cur_st, cur_tk;
        logic         gl, acc, saw_low;
        int           lat, sent, win_acc, exp_win;
        logic [15:0]  cnt0;

        for (int v = 0; v < 16; v++) begin
            xv = 4'(v);
            a0 = xv[3]; a1 = xv[2]; a2 = xv[1]; a3 = xv[0];
            b1 = (a0 & a1) ^ a2;
            b0 = (a3 & a0) ^ a1;
            b3 = (b1 & a3) ^ a0;
            b2 = (b0 & b1) ^ a3;
            inv_tab[{b0, b1, b2, b3}] = xv;
        end

        tbl[0] = '{st: 128'h0, tk: 128'h0, last: 1'b0, exp: 128'h0};
        tbl[1] = '{st: 128'hFFFFFFFF_00000000_00000000_00000000, tk: 128'h0, last: 1'b0,
                   exp: 128'h00000000_FFFFFFFF_00000000_00000000};
        tbl[2] = '{st: {128{1'b1}}, tk: 128'h00000000_00000000_00000000_0000000F, last: 1'b0,
                   exp: 128'hFFFFFFFF_FFFFFFFF_00000000_0000000F};
        tbl[3] = '{st: 128'h00000000_FFFFFFFF_00000000_00000000, tk: 128'h0, last: 1'b1,
                   exp: 128'h00000000_00000000_FFFFFFFF_00000000};
        tbl[4] = '{st: 128'h00000000_00000000_00000000_FFFFFFFF,
                   tk: 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0, last: 1'b0,
                   exp: 128'hEDCBA987_9ABCDEF0_0F0F0F0F_F0F0F0F0};

        rst = 1'b1; in_valid = 1'b0; in_state = '0; in_tk = '0; in_last = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_out_state", out_state, 128'h0);
        chk("rst_beat_cnt", 128'(beat_cnt), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        for (int i = 0; i < 5; i++) begin
            one_beat(tbl[i].st, tbl[i].tk, tbl[i].last, got, gl, lat);
            chk($sformatf("tbl%0d_state", i), got, tbl[i].exp);
            chk($sformatf("tbl%0d_last", i), 128'(gl), 128'(tbl[i].last));
            chk($sformatf("tbl%0d_latency", i), 128'(lat), 128'(2));
            if (i == 0) chk("first_beat_cnt", 128'(beat_cnt), 128'(1));
        end

        // Backpressure window: out_ready low for cycles 3..6 of an 8-beat stream.
        wait_idle("drain_pre_stream");
        cnt0 = beat_cnt; sent = 0; win_acc = 0; saw_low = 1'b0;
        cur_st = {$urandom, $urandom, $urandom, $urandom};
        cur_tk = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 30; c++) begin
            drive(sent < 8, cur_st, cur_tk, sent == 7, !(c >= 3 && c <= 6), acc);
            if (sent < 8 && !acc) saw_low = 1'b1;
            if (acc) begin
                sent++;
                if (c >= 3 && c <= 6) win_acc++;
                cur_st = {$urandom, $urandom, $urandom, $urandom};
                cur_tk = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        wait_idle("drain_stream");
`ifdef CLYDE_INVS_SKID_EN
        exp_win = 1;
`else
        exp_win = 0;
`endif
        chk("stream_sent", 128'(sent), 128'(8));
        chk("stream_in_ready_drop", 128'(saw_low), 128'(1));
        chk("stream_window_accepts", 128'(win_acc), 128'(exp_win));
        chk("stream_beat_cnt", 128'(beat_cnt), 128'(cnt0 + 16'd8));

        // Reset with two beats in flight.
        drive(1'b1, 128'h1, 128'h2, 1'b0, 1'b0, acc);
        drive(1'b1, 128'h3, 128'h4, 1'b0, 1'b0, acc);
        do_reset();
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_beat_cnt", 128'(beat_cnt), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        one_beat(tbl[4].st, tbl[4].tk, 1'b1, got, gl, lat);
        chk("midrst_state", got, tbl[4].exp);
        chk("midrst_latency", 128'(lat), 128'(2));
        chk("midrst_last", 128'(gl), 128'(1));

        // Random valid/ready traffic against the scoreboard.
        cur_st = {$urandom, $urandom, $urandom, $urandom};
        cur_tk = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 300; c++) begin
            drive(($urandom % 4) != 0, cur_st, cur_tk, 1'($urandom), 1'($urandom), acc);
            if (acc) begin
                cur_st = {$urandom, $urandom, $urandom, $urandom};
                cur_tk = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        wait_idle("drain_random");

        // Counter wrap.
        do_reset();
        sent = 0;
        while (sent < 65535) begin
            drive(1'b1, {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, acc);
            if (acc) sent++;
        end
        wait_idle("drain_wrap");
        chk("cnt_ffff", 128'(beat_cnt), 128'(16'hFFFF));
        one_beat(tbl[2].st, tbl[2].tk, 1'b0, got, gl, lat);
        chk("wrap_state", got, tbl[2].exp);
        chk("cnt_wrap", 128'(beat_cnt), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
